// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: stepped upward frequency sweep sequencer for top_nco.
// Handshake: start is a level request sampled only while idle (no ready/ack,
// no queueing); abort is a level request honoured in any non-idle state and
// takes priority over every other transition. All outputs are registered.
module nco_sweep_ctrl #(
    parameter int FCW_W    = 15,
    parameter int DWELL_W  = 16,
    parameter int SYNC_CYC = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [FCW_W-1:0]   cfg_start,
    input  logic [FCW_W-1:0]   cfg_stop,
    input  logic [FCW_W-1:0]   cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    output logic [FCW_W-1:0]   fcw,
    output logic               initial_phase,
    output logic               busy,
    output logic               done
);

    localparam int SYNC_W = (SYNC_CYC > 1) ? $clog2(SYNC_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [FCW_W-1:0]   sh_start;
    logic [FCW_W-1:0]   sh_stop;
    logic [FCW_W-1:0]   sh_step;
    logic [DWELL_W-1:0] sh_dwell;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [SYNC_W-1:0]  sync_cnt;

    logic [DWELL_W-1:0] dwell_load;
    logic [FCW_W:0]     fcw_sum;
    logic [FCW_W-1:0]   fcw_next;
    logic               last_step;

    // Step arithmetic: one extra bit on the sum so the top of range clamps
    // to stop instead of wrapping; dwell of zero behaves like one cycle.
    always_comb begin
        dwell_load = (sh_dwell == '0) ? '0 : (sh_dwell - DWELL_W'(1));
        fcw_sum    = {1'b0, fcw} + {1'b0, sh_step};
        fcw_next   = (fcw_sum > {1'b0, sh_stop}) ? sh_stop : fcw_sum[FCW_W-1:0];
        last_step  = (fcw == sh_stop) || (sh_step == '0) || (sh_start > sh_stop);
    end

    // Sweep FSM with registered outputs; abort overrides everything when busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            fcw           <= '0;
            initial_phase <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            sh_start      <= '0;
            sh_stop       <= '0;
            sh_step       <= '0;
            sh_dwell      <= '0;
            dwell_cnt     <= '0;
            sync_cnt      <= '0;
        end else if (abort && (state != IDLE)) begin
            state         <= IDLE;
            fcw           <= '0;
            initial_phase <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_start      <= cfg_start;
                        sh_stop       <= cfg_stop;
                        sh_step       <= cfg_step;
                        sh_dwell      <= cfg_dwell;
                        fcw           <= cfg_start;
                        initial_phase <= 1'b1;
                        busy          <= 1'b1;
                        sync_cnt      <= SYNC_W'(SYNC_CYC - 1);
                        state         <= SYNC;
                    end
                end
                SYNC: begin
                    if (sync_cnt == '0) begin
                        initial_phase <= 1'b0;
                        dwell_cnt     <= dwell_load;
                        state         <= DWELL;
                    end else begin
                        sync_cnt <= sync_cnt - SYNC_W'(1);
                    end
                end
                DWELL: begin
                    if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - DWELL_W'(1);
                    end else if (last_step) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        fcw       <= fcw_next;
                        dwell_cnt <= dwell_load;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: per-cycle trace model plus directed sweeps with
// hand-computed cycle counts and FCW sequences.
module tb_nco_sweep_ctrl;

    localparam int FCW_W    = 15;
    localparam int DWELL_W  = 16;
    localparam int SYNC_CYC = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [FCW_W-1:0]   cfg_start = '0;
    logic [FCW_W-1:0]   cfg_stop = '0;
    logic [FCW_W-1:0]   cfg_step = '0;
    logic [DWELL_W-1:0] cfg_dwell = '0;
    logic [FCW_W-1:0]   fcw;
    logic               initial_phase;
    logic               busy;
    logic               done;

    nco_sweep_ctrl #(.FCW_W(FCW_W), .DWELL_W(DWELL_W), .SYNC_CYC(SYNC_CYC)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
        .cfg_dwell(cfg_dwell), .fcw(fcw), .initial_phase(initial_phase),
        .busy(busy), .done(done)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct packed {
        logic [FCW_W-1:0] fcw;
        logic             ip;
        logic             busy;
        logic             done;
    } ent_t;

    ent_t exp_q[$];
    ent_t cur = '0;
    int   checks = 0;
    int   passes = 0;
    int   seq[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Expected output trace for one sweep, one entry per cycle after accept.
    function automatic void build_trace(input int cs, input int ce, input int st, input int dw);
        int d;
        int v;
        int s;
        d = (dw == 0) ? 1 : dw;
        for (int i = 0; i < SYNC_CYC; i++) exp_q.push_back({FCW_W'(cs), 1'b1, 1'b1, 1'b0});
        v = cs;
        forever begin
            for (int i = 0; i < d; i++) exp_q.push_back({FCW_W'(v), 1'b0, 1'b1, 1'b0});
            if (v == ce || st == 0 || cs > ce) break;
            s = v + st;
            v = (s > ce) ? ce : s;
        end
        exp_q.push_back({FCW_W'(v), 1'b0, 1'b0, 1'b1});
    endfunction

    // Scoreboard model: advance the expected outputs on every clock edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= '0;
            exp_q.delete();
        end else if ((cur.busy || cur.done) && abort) begin
            cur <= '0;
            exp_q.delete();
        end else if (!cur.busy && !cur.done && start) begin
            build_trace(int'(cfg_start), int'(cfg_stop), int'(cfg_step), int'(cfg_dwell));
            cur <= exp_q.pop_front();
        end else if (exp_q.size() > 0) begin
            cur <= exp_q.pop_front();
        end else begin
            cur.done <= 1'b0;
        end
    end

    // Compare process: all outputs against the model, every cycle out of reset.
    always @(negedge clk) begin
        if (!rst) chk("cycle_outputs", int'({fcw, initial_phase, busy, done}), int'(cur));
    end

    // driver tasks
    task automatic go(input int cs, input int ce, input int st, input int dw);
        @(negedge clk);
        cfg_start = FCW_W'(cs);
        cfg_stop  = FCW_W'(ce);
        cfg_step  = FCW_W'(st);
        cfg_dwell = DWELL_W'(dw);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the first negedge after accept; returns accept-to-done cycles.
    task automatic wait_done(output int n);
        n = 1;
        seq.delete();
        seq.push_back(int'(fcw));
        while (!done && n < 500) begin
            @(negedge clk);
            n++;
            if (int'(fcw) != seq[$]) seq.push_back(int'(fcw));
        end
        chk("done_within_budget", int'(done), 1);
    endtask

    int n;
    int cnt;
    int found;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_fcw", int'(fcw), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ip_done", int'({initial_phase, done}), 0);
        rst = 1'b0;
        @(negedge clk);

        // T2 basic sweep: 4 + 6*3 + 1 cycles
        go(0, 50, 10, 3);
        chk("t2_sync_ip", int'(initial_phase), 1);
        wait_done(n);
        chk("t2_cycles", n, 23);
        chk("t2_nvalues", seq.size(), 6);
        chk("t2_second_fcw", seq.size() > 1 ? seq[1] : -1, 10);
        chk("t2_done_busy", int'(busy), 0);
        @(negedge clk);
        chk("t2_hold_fcw", int'(fcw), 50);
        chk("t2_done_one_cycle", int'(done), 0);
        repeat (3) @(negedge clk);

        // T3 clamp: 100,110,120,125
        go(100, 125, 10, 2);
        wait_done(n);
        chk("t3_cycles", n, 13);
        chk("t3_nvalues", seq.size(), 4);
        chk("t3_third", seq.size() > 2 ? seq[2] : -1, 120);
        chk("t3_last", seq[$], 125);
        repeat (2) @(negedge clk);

        // T4 degenerate cases and top-of-range
        go(7, 100, 0, 0);
        wait_done(n);
        chk("t4_step0_cycles", n, 6);
        chk("t4_step0_fcw", int'(fcw), 7);
        repeat (2) @(negedge clk);
        go(200, 100, 5, 0);
        wait_done(n);
        chk("t4_inverted_cycles", n, 6);
        chk("t4_inverted_fcw", int'(fcw), 200);
        repeat (2) @(negedge clk);
        go(1, 32767, 32767, 1);
        wait_done(n);
        chk("t4_top_cycles", n, 7);
        chk("t4_top_fcw", int'(fcw), 32767);
        repeat (2) @(negedge clk);

        // T5 abort in second dwell, with a simultaneous start
        go(0, 50, 10, 3);
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            if (fcw == 10) found = 1;
            else @(negedge clk);
        end
        chk("t5_reached_second", found, 1);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("t5_abort_fcw", int'(fcw), 0);
        chk("t5_abort_busy", int'(busy), 0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        chk("t5_no_done_no_restart", cnt, 0);

        // T6 start held through the sweep; cfg changed after acceptance
        @(negedge clk);
        cfg_start = 15'd0; cfg_stop = 15'd20; cfg_step = 15'd10; cfg_dwell = 16'd2;
        start = 1'b1;
        @(negedge clk);
        cfg_start = 15'd5; cfg_stop = 15'd9; cfg_step = 15'd1; cfg_dwell = 16'd1;
        wait_done(n);
        chk("t6_cycles", n, 11);
        chk("t6_last", seq[$], 20);
        @(negedge clk);
        chk("t6_idle_gap", int'({busy, done}), 0);
        @(negedge clk);
        start = 1'b0;
        chk("t6_reaccept", int'({fcw, initial_phase, busy}), int'({15'd5, 1'b1, 1'b1}));
        wait_done(n);
        chk("t6_second_cycles", n, 10);
        chk("t6_second_last", int'(fcw), 9);
        repeat (2) @(negedge clk);

        // T1 asynchronous reset mid-dwell, no clock edge in between
        go(0, 50, 10, 3);
        repeat (6) @(negedge clk);
        chk("t1_pre_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("t1_async_fcw", int'(fcw), 0);
        chk("t1_async_flags", int'({initial_phase, busy, done}), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
